// File: rtl/dmadd_pkg.sv
// Shared types and encodings for the DMADD sequencer and its command FIFO.
package dmadd_pkg;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_INIT,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [1:0] MODE_MIN      = 2'b00;
  localparam logic [1:0] MODE_MAX      = 2'b01;
  localparam logic [1:0] MODE_MADD_MIN = 2'b10;
  localparam logic [1:0] MODE_MADD_MAX = 2'b11;

  localparam logic KIND_LOAD = 1'b0;
  localparam logic KIND_EXEC = 1'b1;

  localparam logic [1:0] INSN_MIN  = 2'b00;
  localparam logic [1:0] INSN_MAX  = 2'b01;
  localparam logic [1:0] INSN_MADD = 2'b10;

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
  } load_entry_t;

  // Instruction driven during LOAD/RUN for a given EXEC mode.
  function automatic logic [1:0] run_insn(input logic [1:0] mode);
    return mode[1] ? INSN_MADD : {1'b0, mode[0]};
  endfunction

endpackage

// File: rtl/dmadd_cmd_fifo.sv
// Small FIFO holding pending LOAD commands; flags are registered.
module dmadd_cmd_fifo
  import dmadd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  load_entry_t push_data,
  input  logic        pop,
  output load_entry_t pop_data,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  load_entry_t mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/dmadd_sequencer.sv
// Command sequencer for the DMADD datapath: queues LOADs, then on EXEC runs
// CLEAR/INIT/LOAD/RUN/DONE and captures the datapath result.
module dmadd_sequencer
  import dmadd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RUN_MAX    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_kind,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_index,
  input  logic [3:0] cmd_data,
  output logic       dp_rst_n,
  output logic [3:0] dp_index,
  output logic [3:0] dp_data,
  output logic [1:0] dp_insn,
  output logic       dp_load,
  output logic       dp_run,
  input  logic [7:0] dp_out,
  input  logic [3:0] dp_out_top,
  output logic       busy,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       timeout
);

  localparam int unsigned CNT_W = $clog2(RUN_MAX + 1);

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        to_hit_q, to_hit_d;
  logic [7:0]  result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic        dp_rst_n_q, dp_rst_n_d;
  logic [3:0]  dp_index_q, dp_index_d;
  logic [3:0]  dp_data_q, dp_data_d;
  logic [1:0]  dp_insn_q, dp_insn_d;
  logic        dp_load_q, dp_load_d;
  logic        dp_run_q, dp_run_d;

  logic        accept;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  load_entry_t fifo_wdata;
  load_entry_t fifo_rdata;

  dmadd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // LOADs are refused in LOAD so push and pop never coincide.
  always_comb begin
    if (cmd_kind == KIND_EXEC) cmd_ready = (state_q == ST_IDLE);
    else                       cmd_ready = !fifo_full && (state_q != ST_LOAD);
    accept     = cmd_valid && cmd_ready;
    fifo_push  = accept && (cmd_kind == KIND_LOAD);
    fifo_wdata = '{index: cmd_index, data: cmd_data};
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    cnt_d          = cnt_q;
    to_hit_d       = to_hit_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_d      = timeout_q;
    fifo_pop       = 1'b0;
    dp_load_d      = 1'b0;
    dp_index_d     = dp_index_q;
    dp_data_d      = dp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && (cmd_kind == KIND_EXEC)) begin
          mode_d  = cmd_mode;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_INIT;
      ST_INIT:  state_d = ST_LOAD;
      ST_LOAD: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          dp_load_d  = 1'b1;
          dp_index_d = fifo_rdata.index;
          dp_data_d  = fifo_rdata.data;
        end else begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (dp_out_top == 4'd0) begin
          to_hit_d = 1'b0;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_W'(RUN_MAX)) begin
          to_hit_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        result_d       = dp_out;
        result_valid_d = 1'b1;
        timeout_d      = to_hit_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Datapath controls are decoded from the next state so they register cleanly.
    busy_d     = (state_d != ST_IDLE);
    dp_rst_n_d = (state_d != ST_CLEAR);
    dp_run_d   = (state_d == ST_RUN);
    case (state_d)
      ST_INIT:                  dp_insn_d = {1'b0, mode_d[0]};
      ST_LOAD, ST_RUN, ST_DONE: dp_insn_d = run_insn(mode_d);
      default:                  dp_insn_d = INSN_MIN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_MIN;
      cnt_q          <= '0;
      to_hit_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
      dp_rst_n_q     <= 1'b0;
      dp_index_q     <= '0;
      dp_data_q      <= '0;
      dp_insn_q      <= INSN_MIN;
      dp_load_q      <= 1'b0;
      dp_run_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      cnt_q          <= cnt_d;
      to_hit_q       <= to_hit_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
      dp_rst_n_q     <= dp_rst_n_d;
      dp_index_q     <= dp_index_d;
      dp_data_q      <= dp_data_d;
      dp_insn_q      <= dp_insn_d;
      dp_load_q      <= dp_load_d;
      dp_run_q       <= dp_run_d;
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;
  assign dp_rst_n     = dp_rst_n_q;
  assign dp_index     = dp_index_q;
  assign dp_data      = dp_data_q;
  assign dp_insn      = dp_insn_q;
  assign dp_load      = dp_load_q;
  assign dp_run       = dp_run_q;

endmodule

// File: doc/dmadd_sequencer.md
DMADD_SEQUENCER -- requirements
Module: dmadd_sequencer

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 4, depth of the load-command FIFO (power of 2); RUN_MAX, default 20, run-cycle limit before timeout.
REQ-002 SHALL have ports `clk`, input, 1, the single clock; `rst_n`, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have ports `cmd_valid`, input, 1, command offered; `cmd_ready`, output, 1, command accepted this cycle.
REQ-004 SHALL have ports `cmd_kind`, input, 1, 0=LOAD, 1=EXEC; `cmd_mode`, input, 2, EXEC mode: 00 MIN, 01 MAX, 10 MADD_MIN, 11 MADD_MAX.
REQ-005 SHALL have ports `cmd_index`, input, 4, LOAD index; `cmd_data`, input, 4, LOAD data.
REQ-006 SHALL have datapath-drive outputs: `dp_rst_n`, 1; `dp_index`, 4; `dp_data`, 4; `dp_insn`, 2; `dp_load`, 1; `dp_run`, 1.
REQ-007 SHALL have datapath-status inputs: `dp_out`, 8, position result; `dp_out_top`, 4, step value, 0 = datapath stopped.
REQ-008 SHALL have status outputs: `busy`, 1, sequence active; `result`, 8, last captured dp_out; `result_valid`, 1, one-cycle pulse; `timeout`, 1, last sequence hit RUN_MAX.

Function
REQ-009 SHALL implement states IDLE, CLEAR, INIT, LOAD, RUN, DONE.
REQ-010 SHALL accept a command when cmd_valid && cmd_ready (handshake on the same rising edge).
REQ-011 SHALL assert cmd_ready for LOAD when the FIFO is not full and state != LOAD.
REQ-012 SHALL assert cmd_ready for EXEC only in IDLE.
REQ-013 SHALL push each accepted LOAD {index,data} into the FIFO; LOADs accepted during RUN/DONE wait for the next EXEC.
REQ-014 SHALL, on an accepted EXEC, latch the mode and go IDLE->CLEAR.
REQ-015 CLEAR (1 cycle): SHALL drive dp_rst_n=0, then go to INIT.
REQ-016 INIT (1 cycle): SHALL drive dp_load=0, dp_run=0, dp_insn={0,mode[0]}, then go to LOAD.
REQ-017 LOAD: SHALL pop one entry per cycle, driving dp_load=1, dp_index/dp_data from the popped entry, dp_insn=L.
REQ-018 L SHALL be 2'b10 if mode[1] else {0,mode[0]}.
REQ-019 LOAD SHALL go to RUN in the cycle after the FIFO empties; an empty FIFO at entry SHALL spend one cycle with dp_load=0.
REQ-020 RUN: SHALL drive dp_run=1, dp_insn=L, dp_load=0, and count cycles from 1.
REQ-021 RUN SHALL go to DONE when dp_out_top==0 is sampled; one extra run cycle with zero step is permitted.
REQ-022 RUN SHALL go to DONE with timeout=1 when the count reaches RUN_MAX while dp_out_top!=0.
REQ-023 DONE (1 cycle): SHALL register result<=dp_out, pulse result_valid, and update timeout, then go to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 All dp_* outputs SHALL be registered and glitch-free; in IDLE: dp_load=0, dp_run=0, dp_insn=2'b00, dp_rst_n=1.
REQ-026 SHALL hold result and timeout until the next DONE.
REQ-027 A simultaneous push and pop SHALL not occur (LOAD is not accepted in LOAD state).

Reset
REQ-028 On rst_n low, at any time including mid-RUN: state=IDLE, FIFO empty, cmd_ready=1 (LOAD), busy=0, result=0, result_valid=0, timeout=0, dp_load=0, dp_run=0, dp_insn=0, dp_index=0, dp_data=0.
REQ-029 dp_rst_n SHALL be low asynchronously while rst_n is low, and also during CLEAR.

Structure
REQ-030 Package dmadd_pkg SHALL hold the state enum, mode codes, cmd_kind codes, and the insn encodings (MIN=00, MAX=01, MADD=10).
REQ-031 The FIFO SHALL be a separate sub-module, dmadd_cmd_fifo, with push/pop/full/empty.

Verification (bench instantiates the DMADD datapath)
REQ-032 LOAD(idx5,d0), EXEC MIN -> CLEAR/INIT/LOAD(1 beat)/RUN; result[3:0]=5, result_valid pulse, timeout=0.
REQ-033 LOAD idx3, LOAD idx9, EXEC MAX -> result[3:0]=9, timeout=0.
REQ-034 EXEC MIN with empty FIFO -> no stop; DONE after 20 RUN cycles, timeout=1.
REQ-035 4 LOADs in IDLE accepted, 5th sees cmd_ready=0; EXEC while busy sees cmd_ready=0.
REQ-036 rst_n low in RUN cycle 3 -> dp_rst_n=0 immediately; all REQ-028 values; a new EXEC after release runs normally.
